spi_master: RTL
===============

# spi_master

Mode-0 SPI master that drives the FPGA-side SPI slave from on-chip logic, for board-level loopback and as the host-side link in standalone test designs. It takes bytes over a valid/ready handshake, frames them with SSEL, and generates SCK, MOSI and MISO sampling. It returns one received byte per transmitted byte. The SCK half-period is a whole number of CLK cycles, slow enough for a slave that oversamples SCK/SSEL/MOSI through 2–3-flop synchronizers.

## Interface
- CLK_DIV, default 4: SCK half-period in CLK cycles; legal range 4..65535; values below 4 are unsupported.
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- TX_DATA  in  8  byte to send, MSB first.
- TX_VALID  in  1  TX_DATA/TX_LAST valid.
- TX_LAST  in  1  accepted byte closes the frame; SSEL deasserts after it.
- TX_READY  out  1  byte accepted on a cycle with TX_VALID && TX_READY.
- RX_DATA  out  8  byte shifted in from MISO during the last completed byte.
- RX_VALID  out  1  one-cycle pulse; RX_DATA is valid that cycle.
- BUSY  out  1  high whenever state != IDLE.
- SCK  out  1  SPI clock; idles low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave; asynchronous and synchronized internally.
- SSEL  out  1  active-low slave select.

## Operation
- Reset values: SCK=0, SSEL=1, MOSI=0, RX_DATA=0x00, RX_VALID=0, BUSY=0. State is IDLE, so TX_READY=1. The MISO synchronizer and all counters reset to 0.
- MISO passes through a 2-flop synchronizer before use.
- **IDLE**: SSEL=1, TX_READY=1.
  - On accept: latch TX_DATA into the shift register and latch TX_LAST, then go to SETUP.
- **SETUP**: lasts CLK_DIV cycles. SSEL=0, SCK=0, MOSI=shift[7].
- **SHIFT**: 8 bits. Each bit is a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles.
  - On the CLK edge ending each high phase: shift synced MISO into the receive register LSB.
  - At the start of each low phase for bits 1..7: MOSI advances to the next bit.
  - During bit 8's low phase, MOSI holds the last bit.
- **End of bit 8's low phase**: RX_DATA is loaded and RX_VALID pulses.
  - If the latched TX_LAST=0: go to WAIT_NEXT.
  - If TX_LAST=1: go to GAP.
- **WAIT_NEXT**: SSEL=0, SCK=0, TX_READY=1. Waits indefinitely; on accept, go to SETUP.
- **GAP**: lasts CLK_DIV cycles. SSEL=1, SCK=0, TX_READY=0. Then go to IDLE. This guarantees a minimum SSEL-high time between frames.
- TX_READY=0 in SETUP, SHIFT and GAP. TX_VALID and TX_DATA are ignored in those states.
- Reset asserted mid-frame:
  - SSEL=1 and SCK=0 immediately (asynchronous).
  - No RX_VALID is issued and the partial byte is discarded.
  - After release, the next frame is fully normal.
- Half-period counter: 16 bits, counts 0..CLK_DIV-1, reloads on every phase change.
- Bit counter: 3 bits, wraps 7→0 at the end of each byte.

## Timing
- Accept at cycle t. At t+1: SSEL=0 and MOSI=D[7].
- Bit k (k=0..7): SCK rises at t+1+(2k+1)·CLK_DIV and falls at t+1+(2k+2)·CLK_DIV.
- RX_VALID=1 at t+1+17·CLK_DIV.
  - TX_LAST=1: SSEL rises in the same cycle; TX_READY=1 again at t+1+18·CLK_DIV.
  - TX_LAST=0: WAIT_NEXT is entered in the same cycle, so TX_READY=1 at t+1+17·CLK_DIV.
- CLK_DIV=4 example: SCK rises at t+5, t+13, …, t+61; RX_VALID at t+69; TX_READY at t+73 after a last byte.
- MOSI is stable for ≥CLK_DIV cycles on each side of every SCK rising edge.
- The MISO sample point is 2·CLK_DIV cycles after the preceding SCK falling edge. This covers slave synchronizer latency plus master synchronizer latency (≤6 cycles).
- Throughput: one byte per 17·CLK_DIV+1 cycles when TX_VALID is held.

## Test plan
- **Reset**: RESET_N low for 5 cycles, mid-simulation → SCK=0, SSEL=1, MOSI=0, RX_VALID=0, BUSY=0, TX_READY=1; all values hold after release.
- **Single byte, CLK_DIV=4**:
  - Stimulus: TX 0xA5 with TX_LAST=1; behavioural mode-0 slave returns 0x3C.
  - Response: MOSI sampled at SCK rising edges = 1,0,1,0,0,1,0,1; exactly 8 SCK rising edges; RX_VALID at t+69 with RX_DATA=0x3C; SSEL low over t+1..t+68; TX_READY at t+73.
- **Three-byte frame with stall**:
  - Stimulus: 0x01, 0x80, 0xFF, with TX_VALID dropped for 10 cycles before the 2nd byte.
  - Response: SSEL low continuously; SCK low throughout the stall; 24 rising edges total; 3 RX_VALID pulses; slave model sees 0x01, 0x80, 0xFF.
- **Reset mid-byte**:
  - Stimulus: RESET_N low right after the 3rd SCK rising edge.
  - Response: SSEL=1 and SCK=0 in the same cycle; no RX_VALID; a following 0x5A frame transfers correctly.
- **Ignored input during transfer**: TX_VALID held high with TX_DATA toggling during SHIFT → only the accepted byte is transmitted; TX_READY stays 0 until the byte ends.
- **Slow clock, CLK_DIV=7**: TX 0xC3 with TX_LAST=1 → RX_VALID at t+120; SSEL high for exactly 7 cycles before TX_READY=1 at t+127.

Source files
------------

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Mode-0 SPI master. Bytes arrive on a valid/ready handshake, are framed by
//   SSEL and shifted out MSB first on MOSI. One received byte is returned on
//   RX_DATA/RX_VALID for every transmitted byte. The SCK half-period is
//   CLK_DIV system clocks, which keeps SCK slow enough for an oversampling
//   slave.
//
// Parameters
//   CLK_DIV   SCK half-period in CLK cycles (4..65535)
//
// Ports
//   CLK       in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   TX_DATA   in   byte to send, MSB first
//   TX_VALID  in   TX_DATA / TX_LAST valid
//   TX_LAST   in   accepted byte closes the frame
//   TX_READY  out  byte accepted when TX_VALID && TX_READY
//   RX_DATA   out  byte shifted in from MISO during the last completed byte
//   RX_VALID  out  one-cycle pulse qualifying RX_DATA
//   BUSY      out  high whenever the FSM is not idle
//   SCK       out  SPI clock, idles low
//   MOSI      out  serial data to slave
//   MISO      in   serial data from slave (asynchronous)
//   SSEL      out  active-low slave select
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  input  logic       TX_LAST,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       BUSY,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_WAIT_NEXT = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state_r;
  logic [15:0] cnt_r;       // half-period counter, 0..CLK_DIV-1
  logic [2:0]  bit_r;       // bit index within the current byte
  logic [6:0]  tx_shift_r;  // bits still to be sent after the one on MOSI
  logic [7:0]  rx_shift_r;
  logic        last_r;      // latched TX_LAST of the byte in flight
  logic        miso_meta_r;
  logic        miso_sync_r;
  logic        cnt_done_s;
  logic        accept_s;

  assign cnt_done_s = (cnt_r == DIV_LAST);
  assign accept_s   = TX_VALID && TX_READY;

  // Two-flop synchronizer for the asynchronous MISO input.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      miso_meta_r <= 1'b0;
      miso_sync_r <= 1'b0;
    end else begin
      miso_meta_r <= MISO;
      miso_sync_r <= miso_meta_r;
    end
  end

  // Transfer FSM with all SPI and handshake outputs registered.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      bit_r      <= 3'd0;
      tx_shift_r <= 7'd0;
      rx_shift_r <= 8'd0;
      last_r     <= 1'b0;
      TX_READY   <= 1'b1;
      RX_DATA    <= 8'h00;
      RX_VALID   <= 1'b0;
      BUSY       <= 1'b0;
      SCK        <= 1'b0;
      MOSI       <= 1'b0;
      SSEL       <= 1'b1;
    end else begin
      RX_VALID <= 1'b0;
      case (state_r)
        // IDLE and WAIT_NEXT accept identically; SSEL is already low in WAIT_NEXT.
        ST_IDLE, ST_WAIT_NEXT: begin
          if (accept_s) begin
            tx_shift_r <= TX_DATA[6:0];
            MOSI       <= TX_DATA[7];
            last_r     <= TX_LAST;
            SSEL       <= 1'b0;
            TX_READY   <= 1'b0;
            BUSY       <= 1'b1;
            cnt_r      <= 16'd0;
            state_r    <= ST_SETUP;
          end else begin
            cnt_r <= 16'd0;
          end
        end
        ST_SETUP: begin
          if (cnt_done_s) begin
            cnt_r   <= 16'd0;
            SCK     <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        // SCK doubles as the phase flag: high phase when SCK=1, low phase otherwise.
        ST_SHIFT: begin
          if (!cnt_done_s) begin
            cnt_r <= cnt_r + 16'd1;
          end else begin
            cnt_r <= 16'd0;
            if (SCK) begin
              SCK        <= 1'b0;
              rx_shift_r <= {rx_shift_r[6:0], miso_sync_r};
              // The last bit stays on MOSI through bit 8's low phase.
              if (bit_r != 3'd7) begin
                MOSI       <= tx_shift_r[6];
                tx_shift_r <= {tx_shift_r[5:0], 1'b0};
              end
            end else begin
              bit_r <= bit_r + 3'd1;
              if (bit_r == 3'd7) begin
                RX_DATA  <= rx_shift_r;
                RX_VALID <= 1'b1;
                if (last_r) begin
                  SSEL    <= 1'b1;
                  state_r <= ST_GAP;
                end else begin
                  TX_READY <= 1'b1;
                  state_r  <= ST_WAIT_NEXT;
                end
              end else begin
                SCK <= 1'b1;
              end
            end
          end
        end
        // Guarantees a minimum SSEL-high time between frames.
        ST_GAP: begin
          if (cnt_done_s) begin
            cnt_r    <= 16'd0;
            TX_READY <= 1'b1;
            BUSY     <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          cnt_r    <= 16'd0;
          SSEL     <= 1'b1;
          SCK      <= 1'b0;
          TX_READY <= 1'b1;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule
